// File: rtl/bp_tethered_mem_responder.sv
// -----------------------------------------------------------------------------
// bp_tethered_mem_responder
//
// Single-outstanding BedRock memory responder. It sits at the slave end of the
// mem_cmd / mem_resp channel and stands in for DRAM or host memory in tethered
// simulations. One command is accepted at a time and serviced against an
// internal line-organised array. The response is returned after latency_p
// wait cycles and is held until the consumer takes it.
//
// Ports
//   clk_i              single clock
//   reset_n_i          asynchronous active-low reset
//   mem_cmd_header_i   command header {payload, size, addr, msg_type}, LSB first
//   mem_cmd_data_i     write data; the bytes to store sit at bit 0
//   mem_cmd_v_i        command valid
//   mem_cmd_ready_o    responder idle and able to accept a command
//   mem_resp_header_o  captured command header, echoed unchanged
//   mem_resp_data_o    read data replicated across the full width; 0 otherwise
//   mem_resp_v_o       response valid
//   mem_resp_yumi_i    consumer takes the response (only while mem_resp_v_o)
//   error_o            sticky: an unsupported msg_type was accepted
// -----------------------------------------------------------------------------
module bp_tethered_mem_responder #(
  parameter  int paddr_width_p   = 40,
  parameter  int block_width_p   = 512,
  parameter  int payload_width_p = 16,
  parameter  int els_p           = 64,
  parameter  int latency_p       = 2,
  localparam int hdr_w           = 7 + paddr_width_p + payload_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic [hdr_w-1:0]         mem_cmd_header_i,
  input  logic [block_width_p-1:0] mem_cmd_data_i,
  input  logic                     mem_cmd_v_i,
  output logic                     mem_cmd_ready_o,

  output logic [hdr_w-1:0]         mem_resp_header_o,
  output logic [block_width_p-1:0] mem_resp_data_o,
  output logic                     mem_resp_v_o,
  input  logic                     mem_resp_yumi_i,

  output logic                     error_o
);

  localparam int lg_bb  = $clog2(block_width_p / 8);  // byte-offset bits in a line
  localparam int lg_blk = $clog2(block_width_p);      // bit-offset bits in a line
  localparam int lg_els = $clog2(els_p);
  localparam int bytes  = block_width_p / 8;
  localparam int cnt_w  = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

  // Header field positions, LSB first.
  localparam int addr_lsb = 4;
  localparam int size_lsb = 4 + paddr_width_p;

  typedef enum logic [1:0] {
    e_ready,
    e_wait,
    e_resp
  } state_e;

  state_e             state_q, state_d;
  logic [cnt_w-1:0]   cnt_q, cnt_d;
  logic [hdr_w-1:0]   resp_header_q;
  logic [block_width_p-1:0] resp_data_q;
  logic               error_q;

  logic [block_width_p-1:0] mem_q [els_p];

  // ---------------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------------
  logic [3:0]        cmd_type;
  logic [2:0]        cmd_size;
  logic [lg_bb-1:0]  cmd_byte;
  logic [lg_els-1:0] line_idx;
  logic              is_rd, is_wr, accept;

  // Upper address bits are deliberately not decoded: the array aliases.
  assign cmd_type = mem_cmd_header_i[3:0];
  assign cmd_size = mem_cmd_header_i[size_lsb +: 3];
  assign cmd_byte = mem_cmd_header_i[addr_lsb +: lg_bb];
  assign line_idx = mem_cmd_header_i[addr_lsb + lg_bb +: lg_els];

  assign is_rd  = (cmd_type == 4'd0) || (cmd_type == 4'd2);
  assign is_wr  = (cmd_type == 4'd1) || (cmd_type == 4'd3);
  assign accept = mem_cmd_v_i && (state_q == e_ready);

  // Effective access size: anything larger than a line covers the whole line,
  // and because the offset is aligned to the effective size it becomes 0.
  logic [2:0]        eff_size;
  logic [lg_bb-1:0]  low_mask;   // byte bits inside one access
  logic [lg_bb-1:0]  byte_off;   // naturally aligned byte offset
  logic [lg_blk-1:0] bit_shamt;  // byte_off in bits
  logic [lg_blk-1:0] bit_mask;   // bit index wrap for replication

  always_comb begin
    // NOTE: every signal written here gets a value before any branch; a path
    // that leaves one unassigned would infer a latch.
    eff_size = cmd_size;
    if (int'(cmd_size) > lg_bb) eff_size = 3'(lg_bb);
    low_mask  = lg_bb'((32'd1 << eff_size) - 32'd1);
    byte_off  = cmd_byte & ~low_mask;
    bit_shamt = {byte_off, 3'b000};
    bit_mask  = lg_blk'((32'd8 << eff_size) - 32'd1);
  end

  // ---------------------------------------------------------------------------
  // Datapath: read extraction/replication and byte-masked write
  // ---------------------------------------------------------------------------
  logic [block_width_p-1:0] rd_shift, rd_data, wr_data;
  logic [bytes-1:0]         wr_be;

  assign rd_shift = mem_q[line_idx] >> bit_shamt;
  assign wr_data  = mem_cmd_data_i << bit_shamt;

  always_comb begin
    rd_data = '0;
    wr_be   = '0;
    // Wrapping the bit index at the access width repeats the selected bytes
    // across the whole response word.
    for (int i = 0; i < block_width_p; i++) begin
      rd_data[i] = rd_shift[lg_blk'(i) & bit_mask];
    end
    // A byte is written when its aligned-down index equals the access offset.
    for (int b = 0; b < bytes; b++) begin
      wr_be[b] = ((lg_bb'(b) & ~low_mask) == byte_off);
    end
  end

  // NOTE: the storage array has no reset; it models memory whose contents are
  // undefined until written, and resetting it would cost a full clear.
  always_ff @(posedge clk_i) begin
    if (accept && is_wr) begin
      for (int b = 0; b < bytes; b++) begin
        if (wr_be[b]) mem_q[line_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      e_ready: begin
        if (mem_cmd_v_i) begin
          if (latency_p == 0) begin
            state_d = e_resp;
          end else begin
            state_d = e_wait;
            cnt_d   = cnt_w'(latency_p);
          end
        end
      end
      e_wait: begin
        // Leave when the count reaches 0 so exactly latency_p cycles are spent.
        cnt_d = cnt_q - cnt_w'(1);
        if (cnt_q == cnt_w'(1)) state_d = e_resp;
      end
      e_resp: begin
        if (mem_resp_yumi_i) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= e_ready;
      cnt_q         <= '0;
      resp_header_q <= '0;
      resp_data_q   <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        resp_header_q <= mem_cmd_header_i;
        resp_data_q   <= is_rd ? rd_data : '0;
        if (!is_rd && !is_wr) error_q <= 1'b1;
      end
    end
  end

  assign mem_cmd_ready_o   = (state_q == e_ready);
  assign mem_resp_v_o      = (state_q == e_resp);
  assign mem_resp_header_o = resp_header_q;
  assign mem_resp_data_o   = resp_data_q;
  assign error_o           = error_q;

endmodule

// File: tb/tb_bp_tethered_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_bp_tethered_mem_responder
//
// Self-checking bench for bp_tethered_mem_responder. A byte-addressed model of
// the storage produces expected read data; directed steps cover the main
// scenarios and a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_bp_tethered_mem_responder;

  localparam int PADDR = 40;
  localparam int BLK   = 512;
  localparam int PAY   = 16;
  localparam int ELS   = 64;
  localparam int LAT   = 2;
  localparam int HDR   = 7 + PADDR + PAY;
  localparam int NBYTE = ELS * (BLK / 8);

  logic             clk;
  logic             rst_n;
  logic [HDR-1:0]   cmd_hdr;
  logic [BLK-1:0]   cmd_data;
  logic             cmd_v;
  logic             cmd_ready;
  logic [HDR-1:0]   resp_hdr;
  logic [BLK-1:0]   resp_data;
  logic             resp_v;
  logic             resp_yumi;
  logic             error;

  bp_tethered_mem_responder #(
    .paddr_width_p  (PADDR),
    .block_width_p  (BLK),
    .payload_width_p(PAY),
    .els_p          (ELS),
    .latency_p      (LAT)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (rst_n),
    .mem_cmd_header_i (cmd_hdr),
    .mem_cmd_data_i   (cmd_data),
    .mem_cmd_v_i      (cmd_v),
    .mem_cmd_ready_o  (cmd_ready),
    .mem_resp_header_o(resp_hdr),
    .mem_resp_data_o  (resp_data),
    .mem_resp_v_o     (resp_v),
    .mem_resp_yumi_i  (resp_yumi),
    .error_o          (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0]     ref_mem [NBYTE];
  logic           err_m;
  logic [BLK-1:0] last_data;
  logic [HDR-1:0] last_hdr;

  task automatic check(input string tag, input logic [BLK-1:0] obs,
                       input logic [BLK-1:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: plain byte arithmetic on a flat byte array.
  function automatic int eff_bytes(input logic [2:0] sz);
    int e;
    e = (int'(sz) > 6) ? 6 : int'(sz);
    return 1 << e;
  endfunction

  function automatic logic [BLK-1:0] model_read(input logic [PADDR-1:0] a,
                                                 input logic [2:0] sz);
    int nb, base, off;
    logic [BLK-1:0] r;
    nb   = eff_bytes(sz);
    base = int'(a[11:6]) * 64;
    off  = (int'(a[5:0]) / nb) * nb;
    for (int i = 0; i < BLK; i++) r[i] = ref_mem[base + off + (i / 8) % nb][i % 8];
    return r;
  endfunction

  task automatic model_write(input logic [PADDR-1:0] a, input logic [2:0] sz,
                             input logic [BLK-1:0] d);
    int nb, base, off;
    nb   = eff_bytes(sz);
    base = int'(a[11:6]) * 64;
    off  = (int'(a[5:0]) / nb) * nb;
    for (int j = 0; j < nb; j++) ref_mem[base + off + j] = d[8*j +: 8];
  endtask

  // One full command/response transaction with ydly cycles of backpressure.
  task automatic do_cmd(input logic [3:0] t, input logic [PADDR-1:0] a,
                        input logic [2:0] sz, input logic [PAY-1:0] pl,
                        input logic [BLK-1:0] d, input int ydly);
    logic [HDR-1:0] h;
    logic [BLK-1:0] exp_d;
    int k;
    h = {pl, sz, a, t};
    @(negedge clk);
    check("ready_idle", BLK'(cmd_ready), BLK'(1));
    cmd_hdr  = h;
    cmd_data = d;
    cmd_v    = 1'b1;
    exp_d = '0;
    if (t == 4'd0 || t == 4'd2) exp_d = model_read(a, sz);
    if (t == 4'd1 || t == 4'd3) model_write(a, sz, d);
    if (t > 4'd3) err_m = 1'b1;
    @(negedge clk);
    cmd_v = 1'b0;
    k = 0;
    while (!resp_v && k < LAT + 10) begin
      @(negedge clk);
      k++;
    end
    check("latency", BLK'(k), BLK'(LAT));
    check("resp_hdr", BLK'(resp_hdr), BLK'(h));
    check("resp_data", resp_data, exp_d);
    check("error", BLK'(error), BLK'(err_m));
    check("ready_busy", BLK'(cmd_ready), BLK'(0));
    last_data = resp_data;
    last_hdr  = resp_hdr;
    for (int c = 0; c < ydly; c++) begin
      @(negedge clk);
      check("hold_v", BLK'(resp_v), BLK'(1));
      check("hold_hdr", BLK'(resp_hdr), BLK'(h));
      check("hold_data", resp_data, exp_d);
      check("hold_ready", BLK'(cmd_ready), BLK'(0));
    end
    resp_yumi = 1'b1;
    @(negedge clk);
    resp_yumi = 1'b0;
    check("post_yumi_v", BLK'(resp_v), BLK'(0));
    check("post_yumi_ready", BLK'(cmd_ready), BLK'(1));
  endtask

  function automatic logic [BLK-1:0] rand_line();
    logic [BLK-1:0] r;
    for (int w = 0; w < BLK / 32; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BLK-1:0]   p, q, line;
    logic [PADDR-1:0] a;
    logic [3:0]       t;
    int               r;

    rst_n     = 1'b0;
    cmd_v     = 1'b0;
    cmd_hdr   = '0;
    cmd_data  = '0;
    resp_yumi = 1'b0;
    err_m     = 1'b0;
    for (int i = 0; i < NBYTE; i++) ref_mem[i] = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", BLK'(cmd_ready), BLK'(1));
    check("rst_v", BLK'(resp_v), BLK'(0));
    check("rst_err", BLK'(error), BLK'(0));
    check("rst_hdr", BLK'(resp_hdr), BLK'(0));
    check("rst_data", resp_data, '0);
    rst_n = 1'b1;

    // Fill every line so later random reads see defined data.
    for (int l = 0; l < ELS; l++) do_cmd(4'd1, PADDR'(l * 64), 3'd6, 16'h0, rand_line(), 0);

    // Full-line round trip.
    p = rand_line();
    do_cmd(4'd1, 40'h80, 3'd6, 16'h1A5, p, 0);
    check("wr_data_zero", last_data, '0);
    do_cmd(4'd0, 40'h80, 3'd6, 16'h1A5, '0, 0);
    check("rt_data", last_data, p);
    check("rt_payload", BLK'(last_hdr[HDR-1 -: PAY]), BLK'(16'h1A5));

    // Partial write over a zero line.
    do_cmd(4'd1, 40'h100, 3'd6, 16'h2, '0, 0);
    do_cmd(4'd3, 40'h108, 3'd2, 16'h3, BLK'(32'hDEADBEEF), 0);
    do_cmd(4'd0, 40'h108, 3'd3, 16'h4, '0, 0);
    line = {8{64'h00000000DEADBEEF}};
    check("partial_rd", last_data, line);

    // Aliasing and alignment.
    q = rand_line();
    do_cmd(4'd1, 40'h80 + 40'(ELS * 64), 3'd6, 16'h5, q, 0);
    do_cmd(4'd2, 40'h80, 3'd6, 16'h6, '0, 0);
    check("alias_rd", last_data, q);
    do_cmd(4'd0, 40'h10B, 3'd2, 16'h7, '0, 0);
    line = {16{32'hDEADBEEF}};
    check("align_rd", last_data, line);

    // Backpressure.
    do_cmd(4'd0, 40'h80, 3'd6, 16'h8, '0, 5);

    // Unsupported msg_type.
    do_cmd(4'd7, 40'h80, 3'd6, 16'h9, rand_line(), 0);
    check("bad_type_hdr", BLK'(last_hdr[3:0]), BLK'(4'd7));
    check("bad_type_data", last_data, '0);
    do_cmd(4'd0, 40'h80, 3'd6, 16'hA, '0, 0);
    check("bad_type_mem", last_data, q);
    check("err_sticky", BLK'(error), BLK'(1));

    // Reset one cycle after accept.
    @(negedge clk);
    cmd_hdr  = {16'hB, 3'd6, 40'h80, 4'd0};
    cmd_v    = 1'b1;
    @(negedge clk);
    cmd_v = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_v", BLK'(resp_v), BLK'(0));
    check("midrst_err", BLK'(error), BLK'(0));
    check("midrst_ready", BLK'(cmd_ready), BLK'(1));
    err_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(4'd0, 40'h80, 3'd6, 16'hC, '0, 0);
    check("post_rst_rd", last_data, q);

    // Randomized traffic against the byte model.
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 19);
      t = (r < 18) ? 4'(r % 4) : 4'($urandom_range(4, 15));
      a[31:0]  = $urandom;
      a[39:32] = 8'($urandom);
      do_cmd(t, a, 3'($urandom_range(0, 7)), 16'($urandom), rand_line(),
             $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/bp_tethered_mem_responder.md
# bp_tethered_mem_responder

Single-outstanding BedRock memory responder for the tethered testbench: the slave end of the `mem_cmd`/`mem_resp` channel that the DUT wrapper drives. It accepts one memory command at a time, performs the read or write against an internal line-organised storage array, and returns the matching response after a fixed programmable latency. It stands in for DRAM/host memory in unicore and multicore tethered simulations.

## Interface
- `paddr_width_p`, 40, physical address width.
- `block_width_p`, 512, data field width in bits; a power of 2, at least 64.
- `payload_width_p`, 16, opaque payload field (LCE id/way); echoed unchanged.
- `els_p`, 64, storage lines of `block_width_p` bits; a power of 2.
- `latency_p`, 2, extra wait cycles between accept and response; 0 is legal.
- Header layout, LSB first: `msg_type`[3:0], `addr`[paddr_width_p], `size`[2:0], `payload`[payload_width_p]. Header width is hdr_w = 7 + paddr_width_p + payload_width_p.
- `clk_i` in 1 — single clock.
- `reset_n_i` in 1 — asynchronous, active-low reset.
- `mem_cmd_header_i` in hdr_w — command header.
- `mem_cmd_data_i` in block_width_p — write data.
- `mem_cmd_v_i` in 1 — command valid.
- `mem_cmd_ready_o` out 1 — responder can accept (ready/valid).
- `mem_resp_header_o` out hdr_w — response header.
- `mem_resp_data_o` out block_width_p — read data.
- `mem_resp_v_o` out 1 — response valid.
- `mem_resp_yumi_i` in 1 — consumer takes the response. Asserted only while `mem_resp_v_o`=1.
- `error_o` out 1 — sticky flag: an unsupported msg_type was seen.

## Operation
- The FSM has three states.
  - e_ready: `mem_cmd_ready_o`=1.
  - e_wait: latency countdown.
  - e_resp: `mem_resp_v_o`=1.
- Accept: `mem_cmd_v_i & mem_cmd_ready_o` in e_ready. The header is captured. The FSM moves to e_wait with the counter loaded to `latency_p`, or goes directly to e_resp if `latency_p`=0.
- e_wait: the counter decrements each cycle. At 0 the FSM moves to e_resp.
- e_resp: the response is held stable until `mem_resp_yumi_i`, then the FSM returns to e_ready.
- Address decode:
  - lg_bb = log2(block_width_p/8); line index = `addr[lg_bb +: log2(els_p)]`.
  - Upper address bits are ignored, so addresses alias modulo the array size.
  - Byte offset = `addr[lg_bb-1:0]` with the low `size` bits forced to 0 (naturally aligned).
- Size: an access covers 2^size bytes. If 2^size exceeds the line, the access is clamped to the full line at offset 0.
- msg_type 0 (rd) and 2 (uc_rd):
  - The line is read on the accept edge.
  - The 2^size bytes at the offset are placed at `mem_resp_data_o` bit 0 and replicated across the full width.
- msg_type 1 (wr) and 3 (uc_wr):
  - On the accept edge, the 2^size bytes at the offset are written from `mem_cmd_data_i[0 +: 8*2^size]`.
  - Bytes outside that range are unchanged.
  - Response data = 0.
- Other msg_type values:
  - Storage is untouched.
  - The response is still returned, with data = 0.
  - `error_o` sets to 1 and holds until reset.
- Response header = captured command header, unchanged in every field including msg_type.
- Storage is not reset; its contents are X until written.

## Timing
- Reset (`reset_n_i`=0, asynchronous), applied immediately:
  - state = e_ready, counter = 0, `error_o`=0, `mem_resp_v_o`=0, `mem_resp_header_o`/`mem_resp_data_o`=0.
  - `mem_cmd_ready_o` reads 1 during reset; `mem_cmd_v_i` is required low while reset is asserted.
- Reset mid-operation: any pending response is dropped and the FSM returns to e_ready. Storage writes already performed persist.
- Accept at edge T: `mem_resp_v_o`=1 from cycle T+1+latency_p.
- Yumi at edge R: `mem_resp_v_o`=0 and `mem_cmd_ready_o`=1 from cycle R+1.
- Minimum command spacing is 2+latency_p cycles. There is no combinational path from `mem_resp_yumi_i` to `mem_cmd_ready_o`.
- All outputs are registered or decoded from state only. There are no input-to-output combinational paths.
- Read-after-write to the same line in back-to-back commands returns the new data.

## Test plan
- Full-line round trip, latency_p=2: wr addr 0x80, size 6, data pattern P, accepted at T, yumi immediate → resp_v at T+3, data 0. Then rd 0x80, size 6 → data P, header echoes payload 0x1A5.
- Partial write: wr addr 0x108, size 2, data 0xDEADBEEF, over a line of zeros; then rd 0x108, size 3 → low 64 bits 0x00000000DEADBEEF, replicated 8 times across 512 bits.
- Aliasing and alignment: wr 0x80 + els_p*64 with data Q → rd 0x80 returns Q. Rd 0x10B, size 2 → returns bytes at 0x108.
- Backpressure: hold yumi low for 5 cycles in e_resp → header and data stable, `mem_cmd_ready_o`=0 throughout; ready=1 the cycle after yumi.
- Unsupported msg_type 7 → response with type 7 and data 0, `error_o`=1 sticky across later good commands; storage unchanged.
- Reset mid-wait: assert `reset_n_i`=0 one cycle after accept → `mem_resp_v_o`=0 immediately, `error_o`=0; after release, a new rd completes normally.
